// File: rtl/fifo_pkg.sv
// Shared defaults, state encoding and burst-length width derivation for the
// FIFO burst reader.
package fifo_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int FIFO_SIZE_DEF = 16;

    // One extra bit so a burst can cover the whole FIFO depth.
    function automatic int len_width(input int fifo_size);
        return $clog2(fifo_size) + 1;
    endfunction

    localparam int LEN_WIDTH_DEF = len_width(FIFO_SIZE_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry first-in/first-out valid/ready buffer that absorbs words arriving
// one cycle after the FIFO pop. Flush drops everything, including a same-cycle capture.
module fifo_out_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             push;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = ent0;
    assign push      = in_valid;
    assign pop       = out_valid && out_ready;

    // ent0 is always the head; it only changes on a pop or on a push into
    // an empty buffer, which keeps out_data stable under backpressure.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        ent0  <= in_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        ent1  <= in_data;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= in_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller for syn_fifo: pops a programmed number of words and
// streams them out on valid/ready, hiding the FIFO's registered read latency.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FIFO_SIZE = FIFO_SIZE_DEF,
    parameter int LEN_WIDTH = len_width(FIFO_SIZE)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rdata,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic [1:0]           dbg_state
);

    state_t               state;
    state_t               state_nxt;
    logic                 done_nxt;
    logic [LEN_WIDTH-1:0] issue_left;
    logic [LEN_WIDTH-1:0] beat_left;
    logic                 inflight;
    logic [1:0]           buf_count;
    logic [2:0]           occupancy;
    logic                 pop;
    logic                 flush;

    // Handshake: a beat moves on m_valid && m_ready; m_data holds while
    // m_valid is high and m_ready low; m_ready is don't-care when m_valid is low.
    assign pop       = m_valid && m_ready;
    assign busy      = (state != IDLE);
    assign flush     = busy && abort;
    assign dbg_state = state;

    // Words already committed to the buffer after this cycle settles.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == READ) && !abort && !fifo_empty &&
                        (issue_left != '0) && (occupancy < 3'd2);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) state_nxt = READ;
                    else           done_nxt  = 1'b1;
                end
            end
            READ: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if ((issue_left == '0) ||
                             (fifo_rd_en && issue_left == LEN_WIDTH'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pop && beat_left == LEN_WIDTH'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            issue_left <= '0;
            beat_left  <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (state == IDLE) begin
                if (start && len != '0) begin
                    issue_left <= len;
                    beat_left  <= len;
                end
            end else if (abort) begin
                issue_left <= '0;
                beat_left  <= '0;
            end else begin
                if (fifo_rd_en) issue_left <= issue_left - LEN_WIDTH'(1);
                if (pop && beat_left != '0) beat_left <= beat_left - LEN_WIDTH'(1);
            end
        end
    end

    fifo_out_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .res      (res),
        .flush    (flush),
        .in_valid (inflight),
        .in_data  (fifo_rdata),
        .out_valid(m_valid),
        .out_data (m_data),
        .out_ready(m_ready),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based syn_fifo stand-in, a negedge
// monitor, and one task per scenario checking against expected word streams.
module tb_fifo_burst_reader;

    localparam int W  = 8;
    localparam int FS = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic [LW-1:0] len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_rdata = '0;
    logic          fifo_empty;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(W), .FIFO_SIZE(FS), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .dbg_state (dbg_state)
    );

    // syn_fifo stand-in: registered read data, flags update at the edge.
    logic [W-1:0] fifo_q[$];
    int           fifo_cnt = 0;
    logic         wr_en;
    logic [W-1:0] wr_data;
    bit           underflow = 1'b0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) underflow = 1'b1;
            else fifo_rdata <= fifo_q.pop_front();
        end
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_cnt <= fifo_q.size();
    end
    assign fifo_empty = (fifo_cnt == 0);

    // Monitor: every record is tagged with the cycle it was observed in.
    int           cyc = 0;
    int           rd_cyc[$];
    logic [W-1:0] beat_q[$];
    int           beat_cyc[$];
    int           done_cyc[$];
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!res) begin
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                beat_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
        end
    end

    function automatic int rd_at(input int i);
        return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
    endfunction
    function automatic int beat_cyc_at(input int i);
        return (i < beat_cyc.size()) ? beat_cyc[i] : -1;
    endfunction
    function automatic int done_at(input int i);
        return (i < done_cyc.size()) ? done_cyc[i] : -1;
    endfunction
    function automatic logic [W-1:0] beat_at(input int i);
        return (i < beat_q.size()) ? beat_q[i] : 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = LW'(l);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    // Waits for done; mx tracks the largest issued-but-undelivered word count.
    task automatic wait_done(input int budget, input int rd0, input int b0,
                             output bit ok, inout int mx);
        int o;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            o = (rd_cyc.size() - rd0) - (beat_q.size() - b0);
            if (o > mx) mx = o;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, m_valid, fifo_rd_en} !== 4'b0 || m_data !== '0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_immediate busy=%b done=%b m_valid=%b rd_en=%b m_data=%h state=%0d want all 0",
                     busy, done, m_valid, fifo_rd_en, m_data, dbg_state);
        end
        tick();
        tick();
        res = 1'b0;
        tick();
        checks++;
        if ({busy, done, m_valid, fifo_rd_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b done=%b m_valid=%b rd_en=%b want 0",
                     busy, done, m_valid, fifo_rd_en);
        end
    endtask

    task automatic test_full_rate();
        int rd0, b0, d0, mx, bad;
        bit ok;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(W'(8'h10 + i));
        rd0 = rd_cyc.size(); b0 = beat_q.size(); d0 = done_cyc.size(); mx = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(W'(8'h10 + i));
        start_burst(16);
        wait_done(100, rd0, b0, ok, mx);
        checks++;
        if (!ok) begin failures++; $display("FAIL full_timeout done never seen"); end
        checks++;
        if (rd_cyc.size() - rd0 != 16) begin
            failures++; $display("FAIL full_rd_count got=%0d want=16", rd_cyc.size() - rd0);
        end
        checks++;
        if (rd_at(rd0 + 15) - rd_at(rd0) != 15) begin
            failures++; $display("FAIL full_rd_consecutive span=%0d want=15", rd_at(rd0 + 15) - rd_at(rd0));
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() != 0 && beat_at(b0 + i) !== exp_q.pop_front()) bad++;
        end
        checks++;
        if (bad != 0 || beat_q.size() - b0 != 16) begin
            failures++; $display("FAIL full_data wrong=%0d beats=%0d want 0 wrong, 16 beats", bad, beat_q.size() - b0);
        end
        checks++;
        if (beat_cyc_at(b0) - rd_at(rd0) != 2) begin
            failures++; $display("FAIL full_latency got=%0d want=2", beat_cyc_at(b0) - rd_at(rd0));
        end
        checks++;
        if (beat_cyc_at(b0 + 15) - beat_cyc_at(b0) != 15) begin
            failures++; $display("FAIL full_beat_consecutive span=%0d want=15", beat_cyc_at(b0 + 15) - beat_cyc_at(b0));
        end
        checks++;
        if (done_at(d0) != beat_cyc_at(b0 + 15) + 1 || busy !== 1'b0) begin
            failures++; $display("FAIL full_done_timing done_cyc=%0d last_beat=%0d busy=%b want last+1, busy 0",
                                 done_at(d0), beat_cyc_at(b0 + 15), busy);
        end
        checks++;
        if (fifo_empty !== 1'b1 || underflow) begin
            failures++; $display("FAIL full_fifo_state empty=%b underflow=%b want 1/0", fifo_empty, underflow);
        end
        checks++;
        if (mx > 2) begin failures++; $display("FAIL full_buffer_overflow outstanding=%0d want<=2", mx); end
    endtask

    task automatic test_backpressure();
        int rd0, b0, d0, mx, bad, o;
        bit ok;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(W'(8'hA0 + i));
        rd0 = rd_cyc.size(); b0 = beat_q.size(); d0 = done_cyc.size(); mx = 0; bad = 0;
        start_burst(4);
        for (int i = 0; i < 10; i++) begin
            tick();
            o = rd_cyc.size() - rd0;
            if (o > mx) mx = o;
            if (m_valid && m_data !== 8'hA0) bad++;
        end
        checks++;
        if (rd_cyc.size() - rd0 != 2) begin
            failures++; $display("FAIL bp_rd_count got=%0d want=2", rd_cyc.size() - rd0);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA0 || bad != 0) begin
            failures++; $display("FAIL bp_hold m_valid=%b m_data=%h unstable=%0d want 1/a0/0", m_valid, m_data, bad);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(W'(8'hA0 + i));
        m_ready = 1'b1;
        wait_done(60, rd0, b0, ok, mx);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0 && beat_at(b0 + i) !== exp_q.pop_front()) bad++;
        end
        checks++;
        if (!ok || bad != 0 || beat_q.size() - b0 != 4) begin
            failures++; $display("FAIL bp_data done=%b wrong=%0d beats=%0d want 1/0/4", ok, bad, beat_q.size() - b0);
        end
        checks++;
        if (done_cyc.size() - d0 != 1 || mx > 2) begin
            failures++; $display("FAIL bp_done_count dones=%0d outstanding=%0d want 1/<=2", done_cyc.size() - d0, mx);
        end
    endtask

    task automatic test_fifo_dry();
        int rd0, b0, mx, bad;
        bit ok;
        logic [W-1:0] words[5];
        words = '{8'h31, 8'h32, 8'h33, 8'h55, 8'h66};
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(words[i]);
        rd0 = rd_cyc.size(); b0 = beat_q.size(); mx = 0;
        start_burst(5);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (rd_cyc.size() - rd0 != 3 || fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL dry_stall reads=%0d rd_en=%b busy=%b want 3/0/1",
                                 rd_cyc.size() - rd0, fifo_rd_en, busy);
        end
        push_word(words[3]);
        push_word(words[4]);
        wait_done(60, rd0, b0, ok, mx);
        for (int i = 0; i < 5; i++) exp_q.push_back(words[i]);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() != 0 && beat_at(b0 + i) !== exp_q.pop_front()) bad++;
        end
        checks++;
        if (!ok || bad != 0 || beat_q.size() - b0 != 5 || underflow) begin
            failures++; $display("FAIL dry_data done=%b wrong=%0d beats=%0d underflow=%b want 1/0/5/0",
                                 ok, bad, beat_q.size() - b0, underflow);
        end
    endtask

    task automatic test_zero_len();
        int rd0;
        rd0 = rd_cyc.size();
        start_burst(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
            failures++; $display("FAIL zero_done done=%b busy=%b rd_en=%b m_valid=%b want 1/0/0/0",
                                 done, busy, fifo_rd_en, m_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_cyc.size() != rd0) begin
            failures++; $display("FAIL zero_after done=%b busy=%b reads=%0d want 0/0/0",
                                 done, busy, rd_cyc.size() - rd0);
        end
    endtask

    task automatic test_random();
        int l, p, wi, rd0, b0, d0, mx, bad, o;
        bit ok;
        logic [W-1:0] data[$];
        for (int b = 0; b < 6; b++) begin
            l = $urandom_range(1, 12);
            data.delete();
            for (int i = 0; i < l; i++) data.push_back(W'($urandom_range(0, 255)));
            p = $urandom_range(0, l);
            for (int i = 0; i < p; i++) push_word(data[i]);
            wi = p;
            rd0 = rd_cyc.size(); b0 = beat_q.size(); d0 = done_cyc.size(); mx = 0; ok = 1'b0;
            start_burst(l);
            for (int c = 0; c < 300; c++) begin
                m_ready = ($urandom_range(0, 1) == 1);
                if (wi < l && $urandom_range(0, 1) == 1) begin
                    wr_en = 1'b1; wr_data = data[wi]; wi++;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
                o = (rd_cyc.size() - rd0) - (beat_q.size() - b0);
                if (o > mx) mx = o;
                if (done) begin ok = 1'b1; break; end
            end
            wr_en = 1'b0;
            m_ready = 1'b1;
            @(negedge clk);
            #1;
            for (int i = 0; i < l; i++) exp_q.push_back(data[i]);
            bad = 0;
            for (int i = 0; i < l; i++) begin
                if (exp_q.size() != 0 && beat_at(b0 + i) !== exp_q.pop_front()) bad++;
            end
            checks++;
            if (!ok || bad != 0 || beat_q.size() - b0 != l || done_cyc.size() - d0 != 1) begin
                failures++; $display("FAIL rand_burst%0d done=%b wrong=%0d beats=%0d dones=%0d want 1/0/%0d/1",
                                     b, ok, bad, beat_q.size() - b0, done_cyc.size() - d0, l);
            end
            checks++;
            if (mx > 2 || underflow || fifo_cnt != 0) begin
                failures++; $display("FAIL rand_credit%0d outstanding=%0d underflow=%b fifo_left=%0d want <=2/0/0",
                                     b, mx, underflow, fifo_cnt);
            end
        end
    endtask

    task automatic test_abort();
        int rd0, b0, d0, k, mx;
        bit ok;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(W'(8'h80 + i));
        rd0 = rd_cyc.size(); b0 = beat_q.size(); d0 = done_cyc.size();
        start_burst(8);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (beat_q.size() - b0 >= 2) break;
        end
        m_ready = 1'b0;
        abort = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL abort_rd_en got=%b want=0", fifo_rd_en); end
        tick();
        abort = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_next m_valid=%b busy=%b done=%b want 0/0/0", m_valid, busy, done);
        end
        tick();
        tick();
        k = rd_cyc.size() - rd0;
        checks++;
        if (fifo_cnt != 16 - k || done_cyc.size() != d0 || k < 2) begin
            failures++; $display("FAIL abort_occupancy fifo=%0d reads=%0d dones=%0d want %0d/>=2/0",
                                 fifo_cnt, k, done_cyc.size() - d0, 16 - k);
        end
        m_ready = 1'b1;
        rd0 = rd_cyc.size(); b0 = beat_q.size(); mx = 0;
        exp_q.push_back(W'(8'h80 + k));
        exp_q.push_back(W'(8'h80 + k + 1));
        start_burst(2);
        wait_done(40, rd0, b0, ok, mx);
        checks++;
        if (!ok || beat_q.size() - b0 != 2 || beat_at(b0) !== exp_q[0] || beat_at(b0 + 1) !== exp_q[1]) begin
            failures++; $display("FAIL abort_restart done=%b beats=%0d got=%h,%h want %h,%h",
                                 ok, beat_q.size() - b0, beat_at(b0), beat_at(b0 + 1), exp_q[0], exp_q[1]);
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        int rd0, b0, mx;
        bit ok;
        logic [W-1:0] exp;
        m_ready = 1'b1;
        start_burst(8);
        tick();
        checks++;
        if (busy !== 1'b1 || fifo_rd_en !== 1'b1) begin
            failures++; $display("FAIL areset_pre busy=%b rd_en=%b want 1/1", busy, fifo_rd_en);
        end
        #2;
        res = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            failures++; $display("FAIL areset_immediate busy=%b m_valid=%b rd_en=%b want 0/0/0",
                                 busy, m_valid, fifo_rd_en);
        end
        tick();
        res = 1'b0;
        tick();
        exp = (fifo_q.size() != 0) ? fifo_q[0] : 'x;
        rd0 = rd_cyc.size(); b0 = beat_q.size(); mx = 0;
        start_burst(1);
        wait_done(40, rd0, b0, ok, mx);
        checks++;
        if (!ok || beat_q.size() - b0 != 1 || beat_at(b0) !== exp) begin
            failures++; $display("FAIL areset_restart done=%b beats=%0d got=%h want 1 beat of %h",
                                 ok, beat_q.size() - b0, beat_at(b0), exp);
        end
    endtask

    initial begin
        res = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
        m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_fifo_dry();
        test_zero_len();
        test_random();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
